// File: rtl/box_plotter.sv
// Box / full-screen-clear pixel generator for the vga_adapter plot port.
// One pixel per clock, registered outputs, busy/done handshake, edge clipping.
module box_plotter #(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COLOUR_W  = 3,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int BOX_W     = 4,
  parameter int BOX_H     = 4,
  parameter int BG_COLOUR = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
  input  logic                clear,
  input  logic [X_W-1:0]      in_x,
  input  logic [Y_W-1:0]      in_y,
  input  logic [COLOUR_W-1:0] in_c,
  input  logic                full,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] c,
  output logic                print
);

  localparam logic [X_W:0]        BOX_LAST_C = (X_W+1)'(BOX_W - 1);
  localparam logic [Y_W:0]        BOX_LAST_R = (Y_W+1)'(BOX_H - 1);
  localparam logic [X_W:0]        SCR_LAST_C = (X_W+1)'(SCREEN_W - 1);
  localparam logic [Y_W:0]        SCR_LAST_R = (Y_W+1)'(SCREEN_H - 1);
  localparam logic [X_W:0]        SCR_W_L    = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]        SCR_H_L    = (Y_W+1)'(SCREEN_H);
  localparam logic [COLOUR_W-1:0] BG         = COLOUR_W'(BG_COLOUR);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_CLEAR, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [X_W:0]        col_q, col_d;
  logic [Y_W:0]        row_q, row_d;
  logic [X_W-1:0]      ox_q, ox_d;
  logic [Y_W-1:0]      oy_q, oy_d;
  logic [COLOUR_W-1:0] oc_q, oc_d;
  logic                full_q, full_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOUR_W-1:0] c_q, c_d;
  logic                print_q, print_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [X_W:0] last_col, x_sum;
  logic [Y_W:0] last_row, y_sum;
  logic         border;

  // One extra bit on the sums so an off-screen coordinate is not mistaken for a wrapped one.
  assign x_sum  = {1'b0, ox_q} + col_q;
  assign y_sum  = {1'b0, oy_q} + row_q;
  assign border = (col_q == '0) || (col_q == BOX_LAST_C) ||
                  (row_q == '0) || (row_q == BOX_LAST_R);

  assign last_col = (state_q == S_CLEAR) ? SCR_LAST_C : BOX_LAST_C;
  assign last_row = (state_q == S_CLEAR) ? SCR_LAST_R : BOX_LAST_R;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      oc_q    <= '0;
      full_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      print_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      oc_q    <= oc_d;
      full_q  <= full_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      print_q <= print_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state, scan counters and request latches.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    oc_d    = oc_q;
    full_d  = full_q;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          state_d = S_CLEAR;
          col_d   = '0;
          row_d   = '0;
        end else if (go) begin
          state_d = S_DRAW;
          col_d   = '0;
          row_d   = '0;
          ox_d    = in_x;
          oy_d    = in_y;
          oc_d    = in_c;
          full_d  = full;
        end
      end
      S_DRAW, S_CLEAR: begin
        if (col_q == last_col) begin
          col_d = '0;
          if (row_q == last_row) begin
            row_d   = '0;
            state_d = S_DONE;
          end else begin
            row_d = row_q + (Y_W+1)'(1);
          end
        end else begin
          col_d = col_q + (X_W+1)'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered pixel outputs are loaded from the current scan position.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    print_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: busy_d = clear | go;
      S_DRAW: begin
        busy_d  = 1'b1;
        x_d     = x_sum[X_W-1:0];
        y_d     = y_sum[Y_W-1:0];
        print_d = (x_sum < SCR_W_L) && (y_sum < SCR_H_L);
        c_d     = (full_q || border) ? oc_q : BG;
      end
      S_CLEAR: begin
        busy_d  = 1'b1;
        x_d     = col_q[X_W-1:0];
        y_d     = row_q[Y_W-1:0];
        print_d = 1'b1;
        c_d     = BG;
      end
      S_DONE:  done_d = 1'b1;
      default: done_d = 1'b0;
    endcase
  end

  assign x     = x_q;
  assign y     = y_q;
  assign c     = c_q;
  assign print = print_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_box_plotter.sv
// Scoreboard bench for box_plotter: expected pixels are queued when a request
// is driven and popped whenever the DUT strobes print.
module tb_box_plotter;

  logic       clock = 1'b0;
  logic       reset, go, clear, full;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_c;
  logic       busy, done, print;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] c;

  int total = 0;
  int bad   = 0;
  logic [17:0] sb[$];

  box_plotter dut (
    .clock(clock), .reset(reset), .go(go), .clear(clear),
    .in_x(in_x), .in_y(in_y), .in_c(in_c), .full(full),
    .busy(busy), .done(done), .x(x), .y(y), .c(c), .print(print)
  );

  always #10 clock = ~clock;

  task automatic check_val(input string tag, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (print === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("sb_has_pixel", sb.size(), 1);
      end else begin
        logic [17:0] e;
        e = sb.pop_front();
        check_val("pixel", {x, y, c}, e);
        check_val("busy_on_print", busy, 1);
      end
    end
  end

  function automatic int push_box(input int ox, input int oy, input logic [2:0] col, input bit fl);
    int n = 0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        int xs = ox + k;
        int ys = oy + r;
        logic [2:0] pc;
        pc = (fl || r == 0 || r == 3 || k == 0 || k == 3) ? col : 3'd0;
        if (xs < 160 && ys < 120) begin
          sb.push_back({8'(xs), 7'(ys), pc});
          n++;
        end
      end
    return n;
  endfunction

  task automatic push_clear();
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        sb.push_back({8'(xx), 7'(yy), 3'd0});
  endtask

  // poke > 0 raises go (with a different origin) for one cycle mid-operation.
  task automatic run_op(input bit do_clear, input bit do_go, input int ox, input int oy,
                        input logic [2:0] col, input bit fl, input int poke);
    int n, exp_pr, cycles, prints;
    if (do_clear) begin
      push_clear();
      n = 19200;
      exp_pr = 19200;
    end else begin
      exp_pr = push_box(ox, oy, col, fl);
      n = 16;
    end
    @(negedge clock);
    in_x = 8'(ox); in_y = 7'(oy); in_c = col; full = fl;
    go = do_go; clear = do_clear;
    @(posedge clock); #1;
    go = 1'b0; clear = 1'b0;
    check_val("busy_after_accept", busy, 1);
    cycles = 0;
    prints = 0;
    while (done !== 1'b1 && cycles < n + 8) begin
      @(posedge clock); #1;
      cycles++;
      if (print === 1'b1) prints++;
      if (cycles == poke) begin
        go = 1'b1; in_x = 8'd77; in_y = 7'd5;
      end else begin
        go = 1'b0;
      end
    end
    go = 1'b0;
    check_val("done_latency", cycles, n + 1);
    check_val("print_count", prints, exp_pr);
    check_val("busy_at_done", busy, 0);
    check_val("print_at_done", print, 0);
    check_val("sb_empty", sb.size(), 0);
    @(posedge clock); #1;
    check_val("done_one_cycle", done, 0);
    check_val("busy_after_done", busy, 0);
    sb.delete();
  endtask

  initial begin
    int cycles, prints, dummy;
    reset = 1'b1; go = 1'b0; clear = 1'b0; full = 1'b0;
    in_x = '0; in_y = '0; in_c = '0;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_print", print, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_xyc", {x, y, c}, 0);
    reset = 1'b0;

    // T1 filled, T2 outline
    run_op(1'b0, 1'b1, 10, 20, 3'b100, 1'b1, 0);
    run_op(1'b0, 1'b1, 10, 20, 3'b100, 1'b0, 0);
    // T3 full-screen clear
    run_op(1'b1, 1'b0, 0, 0, 3'b000, 1'b0, 0);
    // T4 clipped at the bottom-right corner
    run_op(1'b0, 1'b1, 158, 118, 3'b010, 1'b1, 0);
    // T5 clear wins over go; go pulse mid-draw ignored
    run_op(1'b1, 1'b1, 40, 40, 3'b111, 1'b1, 0);
    run_op(1'b0, 1'b1, 60, 70, 3'b011, 1'b0, 5);

    // T6 reset at the 6th pixel
    dummy = push_box(30, 40, 3'b101, 1'b1);
    @(negedge clock);
    in_x = 8'd30; in_y = 7'd40; in_c = 3'b101; full = 1'b1; go = 1'b1;
    @(posedge clock); #1;
    go = 1'b0;
    cycles = 0;
    prints = 0;
    while (prints < 6 && cycles < 40) begin
      @(posedge clock); #1;
      cycles++;
      if (print === 1'b1) prints++;
    end
    check_val("t6_prints_before_reset", prints, 6);
    reset = 1'b1;
    @(posedge clock); #1;
    check_val("t6_print", print, 0);
    check_val("t6_busy", busy, 0);
    check_val("t6_done", done, 0);
    sb.delete();
    reset = 1'b0;
    run_op(1'b0, 1'b1, 30, 40, 3'b101, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
